// File: rtl/ds_lif_pkg.sv
// Shared constants and types for the leaky-integrate-and-fire neuron engine.
package ds_lif_pkg;

  localparam int W       = 14;
  localparam int FRAC    = 14;
  localparam int ONE     = 16384;
  localparam int SAT_MAX = 16383;

  typedef logic [W-1:0] pot_t;
  typedef logic [W-1:0] coef_t;

endpackage

// File: rtl/ds_lif_update.sv
// Combinational LIF update: leak and charge multiply-accumulate, Q0.14
// truncation, saturation to the potential range, then the firing compare.
module ds_lif_update
  import ds_lif_pkg::*;
(
  input  pot_t        data_i,
  input  pot_t        syn_i,
  input  coef_t       tau,
  input  coef_t       charge_rate,
  input  pot_t        vth,
  output pot_t        v_sat,
  output logic        fire
);

  localparam logic [FRAC:0]  ONE_W  = FRAC'(0) | (FRAC+1)'(ONE);
  localparam logic [15:0]    SAT_16 = 16'(SAT_MAX);

  logic [2*W-1:0] leak_p;
  logic [FRAC:0]  gain;
  logic [2*W:0]   chg_p;
  logic [2*W+1:0] sum;
  logic [15:0]    v_new;

  // Leak/charge MAC; gain is never zero so charge_rate=0 gives unity input gain.
  always_comb begin
    leak_p = {{W{1'b0}}, data_i} * {{W{1'b0}}, tau};
    gain   = ONE_W - {1'b0, charge_rate};
    chg_p  = {{(W+1){1'b0}}, syn_i} * {{W{1'b0}}, gain};
    sum    = {2'b00, leak_p} + {1'b0, chg_p};
    v_new  = sum[2*W+1:FRAC];
    v_sat  = (v_new > SAT_16) ? pot_t'(SAT_MAX) : v_new[W-1:0];
    fire   = (v_sat >= vth);
  end

endmodule

// File: rtl/ds_lif_neuron.sv
// Single-neuron LIF update engine. Membrane state lives outside the block;
// this level only registers the next potential and the spike flag.
module ds_lif_neuron
  import ds_lif_pkg::*;
(
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic [W-1:0] tau,
  input  logic [W-1:0] charge_rate,
  input  logic [W-1:0] Vrst,
  input  logic [W-1:0] Vth,
  input  logic [W-1:0] syn_i,
  input  logic [W-1:0] data_i,
  output logic         post_spike,
  output logic [W-1:0] data_o
);

  pot_t v_sat;
  logic fire;

  ds_lif_update u_update (
    .data_i      (data_i),
    .syn_i       (syn_i),
    .tau         (tau),
    .charge_rate (charge_rate),
    .vth         (Vth),
    .v_sat       (v_sat),
    .fire        (fire)
  );

  // Output registers: a firing update loads the reset potential instead of v_sat.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      data_o     <= '0;
      post_spike <= 1'b0;
    end else begin
      data_o     <= fire ? Vrst : v_sat;
      post_spike <= fire;
    end
  end

endmodule

// File: tb/tb_ds_lif_neuron.sv
// Self-checking bench for ds_lif_neuron: directed corner cases, randomized
// open-loop updates and a closed-loop run against an arithmetic model.
`timescale 1ns/1ps
module tb_ds_lif_neuron;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic [13:0] tau, charge_rate, Vrst, Vth, syn_i, data_i;
  logic        post_spike;
  logic [13:0] data_o;

  int compared   = 0;
  int mismatched = 0;

  ds_lif_neuron dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .tau         (tau),
    .charge_rate (charge_rate),
    .Vrst        (Vrst),
    .Vth         (Vth),
    .syn_i       (syn_i),
    .data_i      (data_i),
    .post_spike  (post_spike),
    .data_o      (data_o)
  );

  always #5 clk_in = ~clk_in;

  // Reference: V' = floor((V*tau + syn*(1 - cr)) in Q0.14), clamped, then fire test.
  function automatic void lif_model(input int v, input int t, input int cr, input int s,
                                    input int th, input int rst,
                                    output int nv, output bit spk);
    longint total;
    longint v_next;
    total  = longint'(v) * t + longint'(s) * (16384 - cr);
    v_next = total / 16384;
    if (v_next > 16383) v_next = 16383;
    spk = (v_next >= th);
    nv  = spk ? rst : int'(v_next);
  endfunction

  task automatic check_out(input string tag, input int exp_d, input bit exp_s);
    compared++;
    assert (data_o === 14'(exp_d))
      else begin
        mismatched++;
        $error("FAIL %s data_o got %0d expected %0d", tag, data_o, exp_d);
      end
    compared++;
    assert (post_spike === exp_s)
      else begin
        mismatched++;
        $error("FAIL %s post_spike got %0b expected %0b", tag, post_spike, exp_s);
      end
  endtask

  task automatic set_in(input int d, input int s, input int t, input int cr,
                        input int th, input int rst);
    data_i = 14'(d); syn_i = 14'(s); tau = 14'(t);
    charge_rate = 14'(cr); Vth = 14'(th); Vrst = 14'(rst);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  logic [19:0] lfsr;
  int mv, ev, spikes;
  bit es;

  initial begin
    reset_n = 1'b0;
    set_in(1234, 9999, 16000, 100, 0, 777);

    // Reset held for 1000 ns with changing inputs: outputs must stay cleared.
    for (int i = 0; i < 10; i++) begin
      #100;
      set_in($urandom_range(0, 16383), $urandom_range(0, 16383), $urandom_range(0, 16383),
             $urandom_range(0, 16383), 0, 16383);
      check_out("reset_hold", 0, 1'b0);
    end

    // Release away from the edge; the first update lands on the next rising edge.
    @(negedge clk_in);
    reset_n = 1'b1;
    set_in(8000, 0, 8192, 0, 16'h1F00, 0);
    tick();
    check_out("pure_leak", 4000, 1'b0);

    set_in(0, 16383, 0, 8192, 16'h1F00, 100);
    tick();
    check_out("charge_fire", 100, 1'b1);

    set_in(0, 16383, 0, 8192, 8192, 100);
    tick();
    check_out("charge_below", 8191, 1'b0);

    set_in(16383, 0, 16383, 16383, 16382, 55);
    tick();
    check_out("thresh_equal", 55, 1'b1);

    set_in(16383, 0, 16383, 16383, 16383, 55);
    tick();
    check_out("thresh_above", 16382, 1'b0);

    set_in(16383, 16383, 16383, 0, 16'h3FFF, 321);
    tick();
    check_out("saturate", 321, 1'b1);

    set_in(500, 0, 16383, 0, 0, 9000);
    tick();
    check_out("vth_zero", 9000, 1'b1);

    // Vrst above threshold: loaded anyway, and back-to-back spikes have no refractory gap.
    set_in(0, 0, 0, 0, 0, 16000);
    tick();
    check_out("consec_spike", 16000, 1'b1);

    // Asynchronous assertion mid-cycle clears outputs without a clock edge.
    @(negedge clk_in);
    reset_n = 1'b0;
    #1;
    check_out("async_reset", 0, 1'b0);
    @(negedge clk_in);
    reset_n = 1'b1;

    // Randomized open-loop updates, including random thresholds.
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 16383), $urandom_range(0, 16383), $urandom_range(0, 16383),
             $urandom_range(0, 16383), $urandom_range(0, 16383), $urandom_range(0, 16383));
      lif_model(int'(data_i), int'(tau), int'(charge_rate), int'(syn_i),
                int'(Vth), int'(Vrst), ev, es);
      tick();
      check_out("random", ev, es);
    end

    // Closed loop: data_o fed back to data_i, LFSR drive on syn_i.
    lfsr = 20'd8964;
    mv = 0;
    spikes = 0;
    set_in(0, int'(lfsr[13:0]), 14894, 14894, 16'h1F00, 0);
    for (int i = 0; i < 2000; i++) begin
      lif_model(mv, 14894, 14894, int'(syn_i), 16'h1F00, 0, ev, es);
      tick();
      check_out("closed_loop", ev, es);
      if (post_spike === 1'b1) begin
        spikes++;
        compared++;
        assert (data_o === 14'd0)
          else begin
            mismatched++;
            $error("FAIL spike_reset data_o got %0d expected 0", data_o);
          end
      end
      mv = ev;
      data_i = data_o;
      lfsr = {lfsr[18:0], lfsr[19] ^ lfsr[16]};
      syn_i = lfsr[13:0];
    end
    compared++;
    assert (spikes > 0)
      else begin
        mismatched++;
        $error("FAIL closed_loop_spikes got %0d expected >0", spikes);
      end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ds_lif_neuron.md
Name: ds_lif_neuron

Overview:
Single-neuron digital leaky-integrate-and-fire (LIF) update engine; the membrane state is held externally.
- Each clock it reads the present membrane potential on data_i and applies leak and synaptic charge.
- It compares the result against a threshold and registers the next potential on data_o, plus a spike flag.
- data_o is normally looped back to data_i directly or through a state RAM, so one engine can serve one or many neurons.

Parameters:
W, 14, width of potential, synaptic input and all coefficients
FRAC, 14, fractional bits of tau/charge_rate (unity = 2^FRAC = 16384)

Ports:
clk_in  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
tau  in  W  leak coefficient, unsigned Q0.14 (retention factor tau/16384)
charge_rate  in  W  charge coefficient, unsigned Q0.14 (input gain = (16384-charge_rate)/16384)
Vrst  in  W  reset potential loaded after a spike
Vth  in  W  firing threshold, unsigned
syn_i  in  W  synaptic drive for this cycle, unsigned
data_i  in  W  present membrane potential, unsigned
post_spike  out  1  registered spike flag
data_o  out  W  registered next membrane potential

Behaviour:
- Reset (reset_n=0, asynchronous): data_o=0, post_spike=0. Both are held while reset is low. Release is synchronous to the next clk_in rising edge.
- All arithmetic is unsigned, with no signed interpretation anywhere.
- Combinational update, computed every cycle from current inputs:
  - leak_p = data_i * tau (28 bits)
  - gain = 16384 - charge_rate (15 bits, range 1..16384)
  - chg_p = syn_i * gain (29 bits)
  - sum = leak_p + chg_p (30 bits)
  - v_new = sum >> 14 (truncate, no rounding)
  - v_sat = min(v_new, 2^W-1 = 16383)
- Firing: fire = (v_sat >= Vth). The comparison is unsigned and inclusive.
- Registered on each rising clk_in:
  - post_spike <= fire
  - data_o <= fire ? Vrst : v_sat
- Latency: exactly 1 cycle from data_i/syn_i/coefficients to data_o/post_spike. No handshake; a new sample is taken every cycle.
- post_spike is high for exactly the cycle after each firing update. Consecutive firing produces consecutive high cycles; there is no refractory period.
- Boundaries:
  - Vth=0: fires every cycle.
  - Vrst>=Vth: Vrst is loaded anyway; the next update is evaluated normally.
  - charge_rate=0: input gain is ~1.0 (16384/16384).
  - tau=0: full leak; potential comes from input only.
  - Saturation applies before the threshold compare.
- Coefficient and Vth/Vrst changes take effect on the next clock edge. No internal state exists besides the two output registers.
- No X propagation from data_i is required to be filtered; the integrator drives data_i from data_o after reset.

Decomposition:
- Package ds_lif_pkg holds:
  - W=14, FRAC=14, ONE=16384, SAT_MAX=16383
  - typedef pot_t (logic [W-1:0])
  - typedef coef_t (logic [W-1:0])
- Sub-module ds_lif_update is natural: purely combinational leak/charge MAC, shift, saturate and compare. It outputs v_sat and fire.
- The top-level ds_lif_neuron holds only the two registers and the async reset.

Test Plan:
1. Reset: reset_n=0 for 1000 ns with arbitrary inputs -> data_o=0, post_spike=0 throughout; the first update occurs on the first edge after release.
2. Pure leak, open loop:
   - Inputs: data_i=8000, syn_i=0, tau=8192, charge_rate=0, Vth=0x1F00, Vrst=0.
   - Required: next data_o=4000, post_spike=0.
3. Charge to threshold:
   - Inputs: data_i=0, syn_i=16383, charge_rate=8192, tau=0, Vrst=100.
   - v_sat=8191 with Vth=0x1F00 -> post_spike=1, data_o=100.
   - Repeat with Vth=8192 -> post_spike=0, data_o=8191.
4. Threshold edge:
   - Inputs: data_i=16383, tau=16383, syn_i=0, charge_rate=16383; sum yields v_sat=16382.
   - Vth=16382 -> spike, data_o=Vrst.
   - Vth=16383 -> no spike, data_o=16382.
5. Saturation:
   - Inputs: data_i=16383, tau=16383, syn_i=16383, charge_rate=0, Vth=0x3FFF.
   - Required: v_sat=16383, spike, data_o=Vrst.
6. Closed loop, data_o tied to data_i:
   - Stimulus: tau=charge_rate=14894, Vrst=0, Vth=0x1F00, syn_i = low 14 bits of a 20-bit LFSR (seed 8964).
   - Required: every cycle matches the bit-accurate model; at least one spike within 2000 cycles; data_o=0 in each cycle where post_spike=1.
